// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus
// iterative shift-add MUL and restoring DIVU/REMU.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam int IT_MUL = 0;
  localparam int IT_DIV = 1;
  localparam int IT_REM = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       iop_q, iop_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum, dif;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             is_iter;

  assign shamt   = B[SH_W-1:0];
  assign sum     = A + B;
  assign dif     = A - B;
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                   (sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                   (dif[WIDTH-1] != A[WIDTH-1]);
  assign is_iter = (ALUCtl == OP_MUL) ||
                   (ALUCtl == OP_DIVU) ||
                   (ALUCtl == OP_REMU);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUCtl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NOR:  sc_res = ~(A | B);
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = add_ovf;
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = sub_ovf;
      end
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(A) < $signed(B)};
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(A) >>> shamt);
      default: sc_res = '0;
    endcase
  end

  // acc holds product or partial remainder; opa holds
  // multiplicand or dividend/quotient; opb multiplier or divisor
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh, div_dif;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic [WIDTH-1:0] res_it;

  assign mul_acc = opb_q[0] ? acc_q + opa_q : acc_q;
  assign rem_sh  = {acc_q, opa_q[WIDTH-1]};
  assign div_dif = rem_sh - {1'b0, opb_q};
  assign div_ok  = !div_dif[WIDTH];
  assign div_rem = div_ok ? div_dif[WIDTH-1:0]
                          : rem_sh[WIDTH-1:0];
  assign div_quo = {opa_q[WIDTH-2:0], div_ok};

  always_comb begin
    res_it = div_rem;
    unique case (1'b1)
      iop_q[IT_MUL]: res_it = mul_acc;
      iop_q[IT_DIV]: res_it = div_quo;
      default:       res_it = div_rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iop_d   = iop_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (iop_q[IT_MUL]) begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        acc_d = div_rem;
        opa_d = div_quo;
      end
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_DONE;
        out_d   = res_it;
        ovf_d   = 1'b0;
        done_d  = 1'b1;
      end
    end else begin
      // DONE behaves like IDLE so a new op can issue back-to-back
      state_d = S_IDLE;
      if (Start) begin
        if (is_iter) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = '0;
          opa_d   = A;
          opb_d   = B;
          iop_d   = {ALUCtl == OP_REMU,
                     ALUCtl == OP_DIVU,
                     ALUCtl == OP_MUL};
        end else begin
          out_d  = sc_res;
          ovf_d  = sc_ovf;
          done_d = 1'b1;
        end
      end
    end
    zero_d = (out_d == '0);
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iop_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iop_q   <= iop_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ALUOut = out_q;
  assign Zero   = zero_q;
  assign Ovf    = ovf_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed checks for alu_multicycle: single-cycle ops,
// iterative MUL/DIVU/REMU timing, and async reset abort.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [3:0]  ALUCtl;
  logic [31:0] A, B;
  logic [31:0] ALUOut;
  logic        Zero, Ovf, Busy, Done;

  int vectors = 0;
  int miscompares = 0;
  int n;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start),
    .ALUCtl(ALUCtl), .A(A), .B(B),
    .ALUOut(ALUOut), .Zero(Zero), .Ovf(Ovf),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // call #1 after a posedge (or at a negedge); returns #1 after Start edge
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    ALUCtl = op;
    A      = a;
    B      = b;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Start  = 1'b0;
  endtask

  // count Busy cycles after the Start edge, bounded
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (Busy && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    Start  = 1'b0;
    ALUCtl = 4'h0;
    A      = '0;
    B      = '0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_aluout", ALUOut, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_ovf", Ovf, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);

    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    chk("add_done", Done, 1);
    chk("add_out", ALUOut, 32'h8000_0000);
    chk("add_ovf", Ovf, 1);
    chk("add_zero", Zero, 0);
    @(posedge clk); #1;
    chk("add_done_pulse", Done, 0);
    chk("add_hold", ALUOut, 32'h8000_0000);

    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_out", ALUOut, 0);
    chk("sltu_zero", Zero, 1);
    chk("sltu_ovf", Ovf, 0);
    issue(4'b1000, 32'hFFFF_FFFF, 32'h1);
    chk("slt_done_b2b", Done, 1);
    chk("slt_out", ALUOut, 1);

    issue(4'b0110, 32'h8000_0000, 32'h1);
    chk("sub_out", ALUOut, 32'h7FFF_FFFF);
    chk("sub_ovf", Ovf, 1);
    issue(4'b0110, 32'd5, 32'd7);
    chk("sub2_out", ALUOut, 32'hFFFF_FFFE);
    chk("sub2_ovf", Ovf, 0);

    issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("and_out", ALUOut, 32'h00F0_00F0);
    issue(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("or_out", ALUOut, 32'hFFF0_FFF0);
    issue(4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    chk("nor_out", ALUOut, 32'h000F_000F);
    issue(4'b0011, 32'h1, 32'h21);
    chk("sll_out", ALUOut, 32'h2);
    issue(4'b0100, 32'h8000_0000, 32'd31);
    chk("srl_out", ALUOut, 32'h1);
    issue(4'b0101, 32'h8000_0000, 32'h24);
    chk("sra_out", ALUOut, 32'hF800_0000);

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    issue(4'b1111, 32'h1234_5678, 32'h1);
    chk("unk_out", ALUOut, 0);
    chk("unk_zero", Zero, 1);
    chk("unk_ovf", Ovf, 0);
    chk("unk_done", Done, 1);

    // MUL with Start pulses and operand changes while busy
    issue(4'b1001, 32'd12345, 32'd6789);
    chk("mul_busy0", Busy, 1);
    chk("mul_hold", ALUOut, 0);
    n = 0;
    while (Busy && n < 100) begin
      if (n == 5) begin
        ALUCtl = 4'b0010;
        A = 32'h1;
        B = 32'h1;
        Start = 1'b1;
      end else if (n == 12) begin
        ALUCtl = 4'b1010;
        A = 32'hDEAD_BEEF;
        B = 32'h3;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      n++;
      @(posedge clk);
      #1;
      if (n == 6)
        chk("mul_ignore_done", Done, 0);
    end
    Start = 1'b0;
    chk("mul_busy_cycles", n, 32);
    chk("mul_done", Done, 1);
    chk("mul_out", ALUOut, 32'd83810205);
    chk("mul_ovf", Ovf, 0);
    @(posedge clk); #1;
    chk("mul_done_pulse", Done, 0);
    chk("mul_idle", Busy, 0);

    issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy(n);
    chk("mulw_out", ALUOut, 32'h1);

    // back-to-back: next op issued during the DONE cycle
    issue(4'b1010, 32'd100, 32'd7);
    wait_busy(n);
    chk("divu_cycles", n, 32);
    chk("divu_out", ALUOut, 32'd14);
    chk("divu_done", Done, 1);
    issue(4'b1011, 32'd100, 32'd7);
    chk("remu_b2b_busy", Busy, 1);
    wait_busy(n);
    chk("remu_cycles", n, 32);
    chk("remu_out", ALUOut, 32'd2);
    issue(4'b1010, 32'd5, 32'd0);
    wait_busy(n);
    chk("div0_cycles", n, 32);
    chk("div0_out", ALUOut, 32'hFFFF_FFFF);
    issue(4'b1011, 32'd5, 32'd0);
    wait_busy(n);
    chk("rem0_out", ALUOut, 32'd5);
    chk("rem0_zero", Zero, 0);

    // reset mid-DIVU aborts it
    issue(4'b1010, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("abort_busy_pre", Busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_aluout", ALUOut, 0);
    chk("abort_zero", Zero, 1);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_ovf", Ovf, 0);
    n = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (Done) n++;
    end
    chk("abort_no_done", n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0010, 32'd3, 32'd4);
    chk("post_rst_done", Done, 1);
    chk("post_rst_add", ALUOut, 32'd7);
    @(posedge clk); #1;
    n = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (Done) n++;
    end
    chk("no_late_done", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, is the operand/result width in bits; legal range 8..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), is the iteration counter width.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Start  input  1  requests an operation; it is sampled on a rising edge while Busy=0.
REQ-006 ALUCtl  input  4  is the operation select, sampled with Start.
REQ-007 A  input  WIDTH  is operand 1, sampled with Start.
REQ-008 B  input  WIDTH  is operand 2, sampled with Start.
REQ-009 ALUOut  output  WIDTH  is the registered result; it holds until the next Done.
REQ-010 Zero  output  1  is registered and equals (ALUOut==0).
REQ-011 Ovf  output  1  is registered signed overflow for ADD/SUB; it is 0 for all other ops.
REQ-012 Busy  output  1  is high while an iterative operation is in progress.
REQ-013 Done  output  1  is a one-cycle pulse marking that ALUOut/Zero/Ovf were just updated.

Function
REQ-014 Single-cycle ops: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT unsigned; 1100 NOR; 1000 SLT signed; 0011 SLL; 0100 SRL; 0101 SRA.
REQ-015 Shift amount is B[$clog2(WIDTH)-1:0]; upper bits of B are ignored.
REQ-016 SLT results are zero-extended 1 or 0.
REQ-017 ADD/SUB wrap modulo 2^WIDTH.
REQ-018 Ovf=1 when operand signs match (ADD) or differ (SUB) and the result sign differs from A.
REQ-019 Iterative ops: 1001 MUL (low WIDTH bits of unsigned product, shift-add, one bit per cycle); 1010 DIVU quotient and 1011 REMU remainder (restoring, one bit per cycle).
REQ-020 Any other ALUCtl value gives ALUOut=0 and Ovf=0, with single-cycle timing.
REQ-021 FSM has states IDLE, RUN, DONE.
REQ-022 IDLE + Start + single-cycle op: the result registers at that edge, Done=1 for the next cycle, and the FSM stays in IDLE.
REQ-023 IDLE + Start + iterative op: A and B are latched, the counter loads WIDTH, and the FSM goes to RUN with Busy=1.
REQ-024 In RUN, one iteration runs per edge and the counter decrements; when it reaches 0 the FSM goes to DONE.
REQ-025 DONE lasts one cycle: ALUOut/Zero are updated on entry, Done=1, Busy=0, then the FSM returns to IDLE.
REQ-026 Latency from the Start edge n: single-cycle op, Done high after edge n+1; iterative op, Busy high after edges n+1..n+WIDTH and Done high after edge n+WIDTH+1.
REQ-027 Start while Busy=1 is ignored, with no queuing and no effect on the operation in flight.
REQ-028 Start during the DONE cycle is accepted (Busy=0), allowing back-to-back issue.
REQ-029 Operand or ALUCtl changes after the Start edge have no effect on the operation in flight.
REQ-030 DIVU/REMU with B=0: quotient is all ones and remainder is A; timing is unchanged.
REQ-031 Done is never high in two consecutive cycles for a single iterative op; it may repeat for back-to-back single-cycle ops.

Reset
REQ-032 rst_n=0 immediately forces FSM=IDLE, counter=0, ALUOut=0, Ovf=0, Busy=0, Done=0, Zero=1, independent of clk.
REQ-033 Reset asserted mid-operation aborts it; no Done is produced for the aborted op.
REQ-034 After deassertion, the first Start is accepted on the first rising edge with rst_n=1.

Verification
REQ-035 WIDTH=32, ADD A=32'h7FFFFFFF, B=1 -> Done after 1 edge, ALUOut=32'h80000000, Ovf=1, Zero=0.
REQ-036 SLT unsigned vs signed, A=32'hFFFFFFFF, B=1 -> ALUCtl 0111 gives 0 with Zero=1; ALUCtl 1000 gives 1.
REQ-037 MUL A=12345, B=6789 -> Busy for 32 cycles, Done at edge n+33, ALUOut=83810205; Start pulses during Busy are ignored.
REQ-038 DIVU A=100, B=7 -> ALUOut=14; REMU same operands -> ALUOut=2; DIVU A=5, B=0 -> ALUOut=32'hFFFFFFFF; REMU A=5, B=0 -> ALUOut=5.
REQ-039 Assert rst_n=0 at cycle 10 of a DIVU -> outputs match REQ-032 at once, no Done; an ADD 3+4 issued after release -> ALUOut=7.
REQ-040 SRA A=32'h80000000, B=32'h00000024 (shift 4) -> ALUOut=32'hF8000000; unknown ALUCtl 1111 -> ALUOut=0, Zero=1.
